// File: rtl/wmc_timer_pkg.sv
// Shared definitions for the washing-machine cycle timer.
//   WMC_TICKS_PER_SEC    : default clock cycles per second
//   WMC_T20_DURATION_SEC : default timed interval in seconds
//   timer_state_t        : per-edge timer state (IDLE / COUNT)
package wmc_timer_pkg;

    localparam int WMC_TICKS_PER_SEC    = 50000000;
    localparam int WMC_T20_DURATION_SEC = 1200;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } timer_state_t;

endpackage

// File: rtl/wmc_tick_gen.sv
// One-second prescaler for the cycle timer.
// Ports:
//   CLOCK    : system clock, rising-edge active
//   RESET    : synchronous active-high reset
//   clear    : force the prescaler back to 0 on this edge (wins over enable)
//   enable   : advance the prescaler on this edge
//   SEC_TICK : high during the cycle whose edge wraps the prescaler, so the
//              parent can advance its seconds counter on that same edge
module wmc_tick_gen #(
    parameter int TICKS_PER_SEC = 50000000
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic clear,
    input  logic enable,
    output logic SEC_TICK
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;

    assign SEC_TICK = enable && !clear && (presc_q == PRESC_LAST);

    // Next prescaler value: clear, wrap at the terminal count, or advance.
    always_comb begin
        presc_d = presc_q;
        if (clear) begin
            presc_d = {PW{1'b0}};
        end else if (enable) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = {PW{1'b0}};
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end else begin
            presc_d = presc_q;
        end
    end

    // Prescaler register.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            presc_q <= {PW{1'b0}};
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/wmc_cycle_timer.sv
// Washing-machine 20-minute cycle timer.
// Runs while T20START is high and emits a one-cycle T20DONE pulse after
// TICKS_PER_SEC*DURATION_SEC consecutive high edges, restarting at once if
// T20START stays high. Dropping T20START clears everything.
// Optional build macro: WMC_TIMER_PAUSE_EN adds a PAUSE input that freezes
// counting (RUNNING=0, REMAIN_SEC held) while T20START is high.
// Ports:
//   CLOCK      : system clock, rising-edge active
//   RESET      : synchronous active-high reset
//   PAUSE      : lid-open interlock (only with WMC_TIMER_PAUSE_EN)
//   T20START   : run request level
//   T20DONE    : one-cycle pulse at the end of each interval
//   RUNNING    : high while the timer is counting
//   REMAIN_SEC : seconds left in the current interval
module wmc_cycle_timer
    import wmc_timer_pkg::*;
#(
    parameter int TICKS_PER_SEC = WMC_TICKS_PER_SEC,
    parameter int DURATION_SEC  = WMC_T20_DURATION_SEC,
    localparam int SEC_W        = $clog2(DURATION_SEC + 1)
) (
    input  logic             CLOCK,
    input  logic             RESET,
`ifdef WMC_TIMER_PAUSE_EN
    input  logic             PAUSE,
`endif
    input  logic             T20START,
    output logic             T20DONE,
    output logic             RUNNING,
    output logic [SEC_W-1:0] REMAIN_SEC
);

    localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(DURATION_SEC - 1);
    localparam logic [SEC_W-1:0] SEC_FULL = SEC_W'(DURATION_SEC);

    timer_state_t     state_s;
    logic             pause_s;
    logic             advance_s;
    logic             sec_tick_s;
    logic [SEC_W-1:0] sec_cnt_q,  sec_cnt_d;
    logic [SEC_W-1:0] remain_q,   remain_d;
    logic             done_q,     done_d;
    logic             running_q,  running_d;

`ifdef WMC_TIMER_PAUSE_EN
    assign pause_s = PAUSE;
`else
    assign pause_s = 1'b0;
`endif

    // State is decided by the level sampled on each edge, not by history.
    assign state_s   = T20START ? COUNT : IDLE;
    assign advance_s = (state_s == COUNT) && !pause_s;

    wmc_tick_gen #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_tick_gen (
        .CLOCK   (CLOCK),
        .RESET   (RESET),
        .clear   (state_s == IDLE),
        .enable  (advance_s),
        .SEC_TICK(sec_tick_s)
    );

    // Seconds counter, terminal detect and next output values.
    always_comb begin
        sec_cnt_d = sec_cnt_q;
        remain_d  = remain_q;
        done_d    = 1'b0;
        running_d = 1'b0;
        case (state_s)
            IDLE: begin
                sec_cnt_d = {SEC_W{1'b0}};
                remain_d  = {SEC_W{1'b0}};
            end
            COUNT: begin
                if (pause_s) begin
                    // Frozen: counters and display hold, no terminal event.
                    sec_cnt_d = sec_cnt_q;
                    remain_d  = remain_q;
                end else begin
                    running_d = 1'b1;
                    if (sec_tick_s) begin
                        if (sec_cnt_q == SEC_LAST) begin
                            sec_cnt_d = {SEC_W{1'b0}};
                            done_d    = 1'b1;
                        end else begin
                            sec_cnt_d = sec_cnt_q + SEC_W'(1);
                        end
                    end else begin
                        sec_cnt_d = sec_cnt_q;
                    end
                    remain_d = SEC_FULL - sec_cnt_d;
                end
            end
            default: begin
                sec_cnt_d = {SEC_W{1'b0}};
                remain_d  = {SEC_W{1'b0}};
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            sec_cnt_q <= {SEC_W{1'b0}};
            remain_q  <= {SEC_W{1'b0}};
            done_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            sec_cnt_q <= sec_cnt_d;
            remain_q  <= remain_d;
            done_q    <= done_d;
            running_q <= running_d;
        end
    end

    assign T20DONE    = done_q;
    assign RUNNING    = running_q;
    assign REMAIN_SEC = remain_q;

endmodule

// File: tb/tb_wmc_cycle_timer.sv
module tb_wmc_cycle_timer;

    localparam int TPS   = 4;
    localparam int DUR   = 3;
    localparam int N     = TPS * DUR;
    localparam int SEC_W = $clog2(DUR + 1);

    typedef struct packed {
        logic             done;
        logic             running;
        logic [SEC_W-1:0] remain;
    } exp_t;

    logic             CLOCK = 1'b0;
    logic             RESET = 1'b1;
    logic             T20START = 1'b0;
    logic             PAUSE_S = 1'b0;
    logic             T20DONE;
    logic             RUNNING;
    logic [SEC_W-1:0] REMAIN_SEC;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   edge_no = 0;
    int   done_total = 0;
    int   last_done_edge = -1;
    int   k = 0;
    logic [SEC_W-1:0] last_remain = '0;

    wmc_cycle_timer #(
        .TICKS_PER_SEC(TPS),
        .DURATION_SEC (DUR)
    ) dut (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
`ifdef WMC_TIMER_PAUSE_EN
        .PAUSE     (PAUSE_S),
`endif
        .T20START  (T20START),
        .T20DONE   (T20DONE),
        .RUNNING   (RUNNING),
        .REMAIN_SEC(REMAIN_SEC)
    );

    always #5 CLOCK = ~CLOCK;

    // Drive one edge worth of inputs and push the response expected after it.
    task automatic step(input logic st, input logic rs, input logic pz);
        exp_t e;
        @(negedge CLOCK);
        T20START = st;
        RESET    = rs;
        PAUSE_S  = pz;
        edge_no  = edge_no + 1;
        if (rs || !st) begin
            k = 0;
            e = '{done: 1'b0, running: 1'b0, remain: '0};
        end else if (pz) begin
            e = '{done: 1'b0, running: 1'b0, remain: last_remain};
        end else begin
            k = k + 1;
            e.done = 1'b0;
            if (k == N) begin
                k = 0;
                e.done = 1'b1;
            end
            e.running = 1'b1;
            e.remain  = SEC_W'(DUR - (k / TPS));
        end
        last_remain = e.remain;
        exp_q.push_back(e);
    endtask

    task automatic run(input logic st, input int n);
        for (int i = 0; i < n; i++) step(st, 1'b0, 1'b0);
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks = checks + 1;
        if (got != want) begin
            errors = errors + 1;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // Monitor: compare every presented output cycle against the scoreboard.
    always @(posedge CLOCK) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks = checks + 3;
            if (T20DONE !== mon_e.done) begin
                errors = errors + 1;
                $display("FAIL done edge=%0d got=%b want=%b", edge_no, T20DONE, mon_e.done);
            end
            if (RUNNING !== mon_e.running) begin
                errors = errors + 1;
                $display("FAIL running edge=%0d got=%b want=%b", edge_no, RUNNING, mon_e.running);
            end
            if (REMAIN_SEC !== mon_e.remain) begin
                errors = errors + 1;
                $display("FAIL remain edge=%0d got=%0d want=%0d", edge_no, REMAIN_SEC, mon_e.remain);
            end
            if (T20DONE === 1'b1) begin
                done_total     = done_total + 1;
                last_done_edge = edge_no;
            end
        end
    end

    initial begin
        int d0;
        int e0;

        // Reset held with T20START high: everything stays zero.
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        run(1'b0, 2);

        // Held high: pulses after edges 12 and 24.
        d0 = done_total; e0 = edge_no;
        run(1'b1, 26);
        run(1'b0, 1);
        check_int("hold_pulses", done_total - d0, 2);
        check_int("hold_last_edge", last_done_edge - e0, 24);

        // Drop at edge 8: no pulse until edge 20.
        d0 = done_total; e0 = edge_no;
        run(1'b1, 7);
        run(1'b0, 1);
        run(1'b1, 14);
        run(1'b0, 1);
        check_int("drop_pulses", done_total - d0, 1);
        check_int("drop_last_edge", last_done_edge - e0, 20);

        // Low exactly on the would-be terminal edge: no pulse.
        d0 = done_total;
        run(1'b1, 11);
        run(1'b0, 3);
        check_int("terminal_low_pulses", done_total - d0, 0);

        // Reset at edge 5 with start high: pulse after edge 17.
        d0 = done_total; e0 = edge_no;
        run(1'b1, 4);
        step(1'b1, 1'b1, 1'b0);
        run(1'b1, 14);
        run(1'b0, 1);
        check_int("reset_pulses", done_total - d0, 1);
        check_int("reset_last_edge", last_done_edge - e0, 17);

`ifdef WMC_TIMER_PAUSE_EN
        // Pause for edges 5-9: REMAIN holds 2, pulse after edge 17.
        d0 = done_total; e0 = edge_no;
        run(1'b1, 4);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1);
        run(1'b1, 10);
        run(1'b0, 1);
        check_int("pause_pulses", done_total - d0, 1);
        check_int("pause_last_edge", last_done_edge - e0, 17);
`endif

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge CLOCK);
        check_int("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
